// File: rtl/trace_pkg.sv
// Shared types and constants for the writeback trace buffer.
// Optional timestamp field is controlled by the TRACE_TIMESTAMP_EN macro.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } trace_state_e;

    localparam logic MODE_STOP = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    // Default-width entry layout, as seen by host-side decoders.
    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_TS_W   = 16;

    typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
        logic [TRACE_TS_W-1:0]   ts;
`endif
        logic [4:0]              dest;
        logic [TRACE_DATA_W-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
module trace_ram
    import trace_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Entry write; contents are meaningless until the matching pointer says otherwise.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace capture: snoops W-stage register writes into a circular buffer
// drained through a valid/ready port. Define TRACE_TIMESTAMP_EN to add a
// free-running cycle counter stamped into every entry and the rd_ts port.
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wwreg,
    input  logic                       wm2reg,
    input  logic [4:0]                 wdestReg,
    input  logic [DATA_W-1:0]          wr,
    input  logic [DATA_W-1:0]          wdo,
    input  logic                       arm,
    input  logic                       mode,
    input  logic                       trig_en,
    input  logic [4:0]                 trig_reg,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [4:0]                 rd_dest,
    output logic [DATA_W-1:0]          rd_data,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]            rd_ts,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow,
    output logic [1:0]                 state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]   ts;
`endif
        logic [4:0]        dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam int EW = $bits(entry_t);

    trace_state_e    state_reg, state_next;
    logic [PW-1:0]   head_reg, head_next;
    logic [PW-1:0]   tail_reg, tail_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            overflow_reg, overflow_next;
    logic            push, push_req, do_pop, qual, full_int;
    entry_t          wentry, rentry;

    assign qual     = wwreg && (wdestReg != 5'd0);
    assign full_int = (count_reg == CW'(DEPTH));
    assign rd_valid = (count_reg != '0);
    assign do_pop   = rd_valid && rd_ready;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_reg;

    // Free-running capture timestamp, wraps modulo 2^TS_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_reg <= '0;
        else     ts_reg <= ts_reg + 1'b1;
    end

    assign wentry.ts = ts_reg;
    assign rd_ts     = rd_valid ? rentry.ts : '0;
`else
    logic [TS_W-1:0] unused_ts_w;
    assign unused_ts_w = '0;
`endif

    assign wentry.dest = wdestReg;
    assign wentry.data = wm2reg ? wdo : wr;

    // FSM, pointer and occupancy next-state; arm overrides any push or pop.
    always_comb begin
        state_next    = state_reg;
        head_next     = head_reg;
        tail_next     = tail_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        push_req      = 1'b0;
        push          = 1'b0;
        if (arm) begin
            head_next     = '0;
            tail_next     = '0;
            count_next    = '0;
            overflow_next = 1'b0;
            state_next    = trig_en ? ARMED : CAPTURE;
        end else begin
            case (state_reg)
                ARMED: begin
                    if (qual && (wdestReg == trig_reg)) begin
                        push_req   = 1'b1;
                        state_next = CAPTURE;
                    end
                end
                CAPTURE: push_req = qual;
                DONE:    if (qual) overflow_next = 1'b1;
                default: ;
            endcase
            // A full STOP-mode buffer with no slot freed this cycle drops the write.
            if (push_req && full_int && (mode == MODE_STOP) && !do_pop) begin
                overflow_next = 1'b1;
                state_next    = DONE;
            end else begin
                push = push_req;
                if (push)   tail_next = tail_reg + 1'b1;
                if (do_pop) head_next = head_reg + 1'b1;
                // WRAP overwrite: oldest entry is discarded by advancing head.
                if (push && full_int && !do_pop) begin
                    head_next     = head_reg + 1'b1;
                    overflow_next = 1'b1;
                end
                if (push && !do_pop && !full_int) count_next = count_reg + 1'b1;
                else if (!push && do_pop)         count_next = count_reg - 1'b1;
                if (push && (mode == MODE_STOP) && (count_next == CW'(DEPTH)))
                    state_next = DONE;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    trace_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (tail_reg),
        .wdata (wentry),
        .raddr (head_reg),
        .rdata (rentry)
    );

    // Outputs read zero while the buffer is empty so reset values are clean.
    assign rd_dest  = rd_valid ? rentry.dest : 5'd0;
    assign rd_data  = rd_valid ? rentry.data : '0;
    assign count    = count_reg;
    assign full     = full_int;
    assign overflow = overflow_reg;
    assign state    = state_reg;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer (DEPTH=4).
module tb_wb_trace_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int TS_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wwreg = 1'b0, wm2reg = 1'b0;
    logic [4:0]        wdestReg = '0;
    logic [DATA_W-1:0] wr = '0, wdo = '0;
    logic              arm = 1'b0, mode = 1'b0, trig_en = 1'b0;
    logic [4:0]        trig_reg = '0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [4:0]        rd_dest;
    logic [DATA_W-1:0] rd_data;
    logic [TS_W-1:0]   ts_a, ts_b, ts_diff;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   rd_ts;
`endif
    logic [2:0]        count;
    logic              full, overflow;
    logic [1:0]        state;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    wb_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .rst(rst), .wwreg(wwreg), .wm2reg(wm2reg), .wdestReg(wdestReg),
        .wr(wr), .wdo(wdo), .arm(arm), .mode(mode), .trig_en(trig_en),
        .trig_reg(trig_reg), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_dest(rd_dest), .rd_data(rd_data),
`ifdef TRACE_TIMESTAMP_EN
        .rd_ts(rd_ts),
`endif
        .count(count), .full(full), .overflow(overflow), .state(state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_arm(input logic m, input logic te, input logic [4:0] tr);
        mode = m; trig_en = te; trig_reg = tr; arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    // One retiring write; the unselected source carries junk to prove the mux.
    task automatic wb(input logic [4:0] d, input logic [31:0] v, input logic m2r);
        wwreg = 1'b1; wdestReg = d; wm2reg = m2r;
        wr  = m2r ? 32'hDEAD_0000 : v;
        wdo = m2r ? v : 32'hBEEF_0000;
        step();
        wwreg = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [4:0] d, input logic [31:0] v);
        chk({tag, ".valid"}, 64'(rd_valid), 64'd1);
        chk({tag, ".dest"},  64'(rd_dest),  64'(d));
        chk({tag, ".data"},  64'(rd_data),  64'(v));
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    initial begin
        // Reset values
        step(); step();
        chk("rst.state", 64'(state), 64'd0);
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.full", 64'(full), 64'd0);
        chk("rst.ovf", 64'(overflow), 64'd0);
        chk("rst.valid", 64'(rd_valid), 64'd0);
        chk("rst.dest", 64'(rd_dest), 64'd0);
        chk("rst.data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        step();

        // Untriggered capture, $zero filtered, wdo selected
        do_arm(1'b0, 1'b0, 5'd0);
        chk("u.state", 64'(state), 64'd2);
        wb(5'd8, 32'h11, 1'b0);
        chk("u.lat.count", 64'(count), 64'd1);
        chk("u.lat.data", 64'(rd_data), 64'h11);
        wb(5'd0, 32'h99, 1'b0);
        wb(5'd9, 32'hABCD, 1'b1);
        chk("u.count", 64'(count), 64'd2);
        pop_chk("u.r0", 5'd8, 32'h11);
        pop_chk("u.r1", 5'd9, 32'hABCD);
        chk("u.empty", 64'(count), 64'd0);

        // Trigger on reg 10
        do_arm(1'b0, 1'b1, 5'd10);
        chk("t.armed", 64'(state), 64'd1);
        wb(5'd8, 32'h80, 1'b0);
        wb(5'd9, 32'h90, 1'b0);
        chk("t.still", 64'(state), 64'd1);
        chk("t.cnt0", 64'(count), 64'd0);
        wb(5'd10, 32'hA0, 1'b0);
        chk("t.capture", 64'(state), 64'd2);
        wb(5'd11, 32'hB0, 1'b0);
        chk("t.count", 64'(count), 64'd2);
        pop_chk("t.r0", 5'd10, 32'hA0);
        pop_chk("t.r1", 5'd11, 32'hB0);

        // STOP overflow
        do_arm(1'b0, 1'b0, 5'd0);
        for (int i = 1; i <= 4; i++) wb(5'd12, 32'h20 + 32'(i), 1'b0);
        chk("s.done", 64'(state), 64'd3);
        chk("s.full", 64'(full), 64'd1);
        chk("s.ovf0", 64'(overflow), 64'd0);
        wb(5'd12, 32'h25, 1'b0);
        chk("s.ovf1", 64'(overflow), 64'd1);
        chk("s.count", 64'(count), 64'd4);
        for (int i = 1; i <= 4; i++) pop_chk("s.r", 5'd12, 32'h20 + 32'(i));
        chk("s.stay", 64'(state), 64'd3);
        chk("s.empty", 64'(count), 64'd0);

        // WRAP overflow
        do_arm(1'b1, 1'b0, 5'd0);
        chk("w.ovfclr", 64'(overflow), 64'd0);
        for (int i = 1; i <= 6; i++) wb(5'd13, 32'(i), 1'b0);
        chk("w.count", 64'(count), 64'd4);
        chk("w.ovf", 64'(overflow), 64'd1);
        chk("w.state", 64'(state), 64'd2);
        for (int i = 3; i <= 6; i++) pop_chk("w.r", 5'd13, 32'(i));

        // Full WRAP with simultaneous push and pop
        do_arm(1'b1, 1'b0, 5'd0);
        for (int i = 1; i <= 4; i++) wb(5'd14, 32'h40 + 32'(i), 1'b0);
        chk("pp.full", 64'(full), 64'd1);
        chk("pp.head0", 64'(rd_data), 64'h41);
        rd_ready = 1'b1;
        wb(5'd14, 32'h45, 1'b0);
        rd_ready = 1'b0;
        chk("pp.count", 64'(count), 64'd4);
        chk("pp.ovf", 64'(overflow), 64'd0);
        for (int i = 2; i <= 5; i++) pop_chk("pp.r", 5'd14, 32'h40 + 32'(i));

        // Asynchronous reset mid-capture
        do_arm(1'b0, 1'b0, 5'd0);
        for (int i = 1; i <= 3; i++) wb(5'd15, 32'(i), 1'b0);
        chk("r.count3", 64'(count), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("r.async.cnt", 64'(count), 64'd0);
        chk("r.async.st", 64'(state), 64'd0);
        step();
        chk("r.valid", 64'(rd_valid), 64'd0);
        chk("r.data", 64'(rd_data), 64'd0);
        chk("r.ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        step();

        // Arm with same-cycle push and pop
        do_arm(1'b0, 1'b0, 5'd0);
        wb(5'd16, 32'h61, 1'b0);
        wb(5'd16, 32'h62, 1'b0);
        chk("a.count2", 64'(count), 64'd2);
        arm = 1'b1; rd_ready = 1'b1;
        wb(5'd17, 32'h63, 1'b0);
        arm = 1'b0; rd_ready = 1'b0;
        chk("a.count", 64'(count), 64'd0);
        chk("a.state", 64'(state), 64'd2);
        wb(5'd18, 32'h64, 1'b0);
        pop_chk("a.r0", 5'd18, 32'h64);

`ifdef TRACE_TIMESTAMP_EN
        // Consecutive-cycle captures are stamped one cycle apart
        do_arm(1'b0, 1'b0, 5'd0);
        wwreg = 1'b1; wm2reg = 1'b0; wdestReg = 5'd19; wr = 32'h71;
        step();
        wr = 32'h72;
        step();
        wwreg = 1'b0;
        ts_a = rd_ts;
        pop_chk("ts.r0", 5'd19, 32'h71);
        ts_b = rd_ts;
        pop_chk("ts.r1", 5'd19, 32'h72);
        ts_diff = ts_b - ts_a;
        chk("ts.delta", 64'(ts_diff), 64'd1);
`else
        ts_a = '0; ts_b = '0; ts_diff = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
